// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Decode stage with a 16-entry pending-write scoreboard and a
//            one-deep output register. Optional writeback bypass is enabled by
//            defining OPERAND_FETCH_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic [4:0]    rf_addr_a,
  output logic [4:0]    rf_addr_b,
  input  logic [DW-1:0] rf_do_a,
  input  logic [DW-1:0] rf_do_b,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_wr,
  output logic [4:0]    out_op,
  output logic [4:0]    out_rd,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [DW-1:0] out_imm
);

  logic [3:0]    rs1, rs2, rd;
  logic          wr;
  logic          byp_a, byp_b;
  logic          haz_a, haz_b, haz_waw, hazard, issue;
  logic [DW-1:0] opnd_a, opnd_b;

  logic [15:0]   pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic          out_wr_q, out_wr_d;
  logic [4:0]    out_op_q, out_op_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic [DW-1:0] out_a_q, out_a_d;
  logic [DW-1:0] out_b_q, out_b_d;
  logic [DW-1:0] out_imm_q, out_imm_d;

  // Only 16 architectural registers: bit 4 of every register field is dropped.
  assign rs1 = in_instr[19:16];
  assign rs2 = in_instr[14:11];
  assign rd  = in_instr[24:21];
  assign wr  = in_instr[31];

  assign rf_addr_a = {1'b0, rs1};
  assign rf_addr_b = {1'b0, rs2};

`ifdef OPERAND_FETCH_BYPASS_EN
  assign byp_a = wb_en && (wb_addr[3:0] == rs1);
  assign byp_b = wb_en && (wb_addr[3:0] == rs2);
  logic unused_bits;
  assign unused_bits = ^{in_instr[25], in_instr[20], wb_addr[4]};
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{in_instr[25], in_instr[20], wb_addr[4], wb_data};
`endif

  assign opnd_a = byp_a ? wb_data : rf_do_a;
  assign opnd_b = byp_b ? wb_data : rf_do_b;

  // A writeback in flight never resolves WAW: the pending bit is still set.
  assign haz_a   = pending_q[rs1] && !byp_a;
  assign haz_b   = pending_q[rs2] && !byp_b;
  assign haz_waw = wr && pending_q[rd];
  assign hazard  = in_valid && (haz_a || haz_b || haz_waw);

  assign in_ready = !rst && !hazard && (!out_valid_q || out_ready);
  assign issue    = in_valid && in_ready;

  always_comb begin
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_wr_d    = out_wr_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_imm_d   = out_imm_q;

    // Clear first so a same-cycle set of the same register wins.
    if (wb_en)
      pending_d[wb_addr[3:0]] = 1'b0;
    if (issue && wr)
      pending_d[rd] = 1'b1;

    if (issue) begin
      out_valid_d = 1'b1;
      out_wr_d    = wr;
      out_op_d    = in_instr[30:26];
      out_rd_d    = {1'b0, rd};
      out_a_d     = opnd_a;
      out_b_d     = opnd_b;
      out_imm_d   = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_imm_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_wr_q    <= out_wr_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_imm_q   <= out_imm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_wr    = out_wr_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_imm   = out_imm_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Scoreboard bench for operand_fetch with a behavioural register
//            file and hazard model; honours OPERAND_FETCH_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_do_a, rf_do_b;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_wr;
  logic [4:0]  out_op, out_rd;
  logic [31:0] out_a, out_b, out_imm;

  operand_fetch #(.DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_do_a(rf_do_a), .rf_do_b(rf_do_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wr(out_wr), .out_op(out_op), .out_rd(out_rd),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  // External register file: combinational read, written on the writeback port.
  logic [31:0] rf [32];
  assign rf_do_a = rf[rf_addr_a];
  assign rf_do_b = rf[rf_addr_b];
  always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

  typedef struct {
    logic        wr;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  bit   pend [16];
  bit   held;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic wr, input logic [4:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [15:0] imm);
    return {wr, op, rd, rs1, imm};
  endfunction

  // Reference model: decides acceptance from pending set and handshake rules.
  initial begin
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    held = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        for (int i = 0; i < 16; i++) pend[i] = 1'b0;
        held = 1'b0;
      end else begin
        int   r1, r2, rdn;
        bit   ba, bb, haz, rdy, iss;
        exp_t e;
        r1  = int'(in_instr[19:16]);
        r2  = int'(in_instr[14:11]);
        rdn = int'(in_instr[24:21]);
        ba  = BYP && wb_en && (int'(wb_addr[3:0]) == r1);
        bb  = BYP && wb_en && (int'(wb_addr[3:0]) == r2);
        haz = in_valid && ((pend[r1] && !ba) || (pend[r2] && !bb) || (in_instr[31] && pend[rdn]));
        rdy = !haz && (!held || out_ready);
        iss = in_valid && rdy;
        chk("rf_addr_a", {27'd0, rf_addr_a}, r1);
        chk("rf_addr_b", {27'd0, rf_addr_b}, r2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        if (iss) begin
          e.wr  = in_instr[31];
          e.op  = in_instr[30:26];
          e.rd  = 5'(rdn);
          e.a   = ba ? wb_data : rf[r1];
          e.b   = bb ? wb_data : rf[r2];
          e.imm = 32'($signed(in_instr[15:0]));
          sb.push_back(e);
        end
        if (wb_en) pend[int'(wb_addr[3:0])] = 1'b0;
        if (iss && in_instr[31]) pend[rdn] = 1'b1;
        if (iss) held = 1'b1;
        else if (out_ready) held = 1'b0;
      end
    end
  end

  // Monitor: compares the presented bundle against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        if (out_valid && sb.size() != 0) begin
          chk("out_wr", {31'd0, out_wr}, {31'd0, sb[0].wr});
          chk("out_op", {27'd0, out_op}, {27'd0, sb[0].op});
          chk("out_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
          chk("out_a", out_a, sb[0].a);
          chk("out_b", out_b, sb[0].b);
          chk("out_imm", out_imm, sb[0].imm);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy,
                     input logic we, input logic [3:0] wa, input logic [31:0] wd);
    @(posedge clk); #1;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    wb_en     = we;
    wb_addr   = {1'b0, wa};
    wb_data   = wd;
  endtask

  task automatic rand_cycle();
    int          cand[$];
    logic        we;
    logic [3:0]  wa;
    for (int i = 0; i < 16; i++) if (pend[i]) cand.push_back(i);
    we = 1'b0;
    wa = 4'($urandom);
    if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
      we = 1'b1;
      wa = 4'(cand[$urandom_range(0, cand.size() - 1)]);
    end else if ($urandom_range(0, 9) == 0) begin
      we = 1'b1;
    end
    cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, we, wa, $urandom);
  endtask

  initial begin
    // Preload the register file while reset holds the DUT.
    for (int i = 0; i < 16; i++) cyc(1'b1, $urandom, 1'b1, 1'b1, 4'(i), $urandom);
    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);
    @(posedge clk); #3; rst = 1'b0;

    // Back-to-back independent instructions, including imm 0x8000.
    cyc(1'b1, mk(1'b0, 5'd1, 5'd1, 5'd1, 16'h8000), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd2, 5'd2, 5'd2, 16'h0810), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd3, 5'd3, 5'd4, 16'h7FFF), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd4, 5'd4, 5'd6, 16'hFFFF), 1'b1, 1'b0, 4'd0, '0);
    // Address fold: rs1 = 5'b10010, rd bit 4 set.
    cyc(1'b1, mk(1'b0, 5'd5, 5'b10110, 5'b10010, 16'h1234), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);

    // RAW on r3 with writeback two cycles after the producer.
    cyc(1'b1, mk(1'b1, 5'd6, 5'd3, 5'd1, 16'h0000), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd7, 5'd7, 5'd3, 16'h0800), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd7, 5'd7, 5'd3, 16'h0800), 1'b1, 1'b1, 4'd3, 32'h1234);
    cyc(1'b1, mk(1'b0, 5'd7, 5'd7, 5'd3, 16'h0800), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);

    // Backpressure for three cycles.
    cyc(1'b1, mk(1'b0, 5'd8, 5'd1, 5'd2, 16'h1000), 1'b0, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd9, 5'd2, 5'd3, 16'h1800), 1'b0, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd9, 5'd2, 5'd3, 16'h1800), 1'b0, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd9, 5'd2, 5'd3, 16'h1800), 1'b0, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd9, 5'd2, 5'd3, 16'h1800), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);

    // WAW on r5, then same-cycle clear and set of r5.
    cyc(1'b1, mk(1'b1, 5'd10, 5'd5, 5'd0, 16'h0000), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b1, 5'd11, 5'd5, 5'd0, 16'h0000), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b1, 5'd11, 5'd5, 5'd0, 16'h0000), 1'b1, 1'b1, 4'd5, 32'h55);
    cyc(1'b1, mk(1'b1, 5'd11, 5'd5, 5'd0, 16'h0000), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b0, '0, 1'b1, 1'b1, 4'd5, 32'h66);
    cyc(1'b1, mk(1'b1, 5'd12, 5'd5, 5'd0, 16'h0000), 1'b1, 1'b1, 4'd5, 32'h77);
    cyc(1'b1, mk(1'b0, 5'd13, 5'd1, 5'd5, 16'h0000), 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd13, 5'd1, 5'd5, 16'h0000), 1'b1, 1'b1, 4'd5, 32'h88);
    cyc(1'b1, mk(1'b0, 5'd13, 5'd1, 5'd5, 16'h0000), 1'b1, 1'b0, 4'd0, '0);

    // Random traffic with a reset pulse in the middle.
    for (int n = 0; n < 300; n++) rand_cycle();
    cyc(1'b1, mk(1'b1, 5'd14, 5'd9, 5'd0, 16'h0000), 1'b0, 1'b0, 4'd0, '0);
    @(posedge clk); #3; rst = 1'b1;
    cyc(1'b1, $urandom, 1'b0, 1'b0, 4'd0, '0);
    cyc(1'b1, mk(1'b0, 5'd15, 5'd1, 5'd9, 16'h0000), 1'b1, 1'b0, 4'd0, '0);
    @(posedge clk); #3; rst = 1'b0;
    cyc(1'b1, mk(1'b0, 5'd15, 5'd1, 5'd9, 16'h0000), 1'b1, 1'b1, 4'd9, 32'hDEAD);
    for (int n = 0; n < 300; n++) rand_cycle();

    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, 4'd0, '0);
    @(negedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: DW, 32, width of operand and writeback data.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  instruction word present.
REQ-005 in_ready  out  1  stage accepts instruction this cycle.
REQ-006 in_instr  in  32  [31]=wr, [30:26]=op, [25:21]=rd, [20:16]=rs1, [15:11]=rs2, [15:0]=imm.
REQ-007 rf_addr_a / rf_addr_b  out  5 each  register file read addresses.
REQ-008 rf_do_a / rf_do_b  in  DW each  register file combinational read data.
REQ-009 wb_en, wb_addr, wb_data  in  1/5/DW  writeback port, mirrored to register file write port the same cycle.
REQ-010 out_valid  out  1  operand bundle valid.
REQ-011 out_ready  in  1  downstream accepts bundle.
REQ-012 out_wr, out_op, out_rd  out  1/5/5  decoded fields.
REQ-013 out_a, out_b, out_imm  out  DW each  operands, sign-extended imm.

Function
REQ-014 Register fields use bits [3:0] only; rf_addr_a = {0,rs1[3:0]}, rf_addr_b = {0,rs2[3:0]}, out_rd = {0,rd[3:0]}; bit 4 ignored.
REQ-015 rf_addr_a/b driven combinationally from in_instr every cycle regardless of in_valid.
REQ-016 Scoreboard: 16 pending bits, one per register.
REQ-017 Hazard when in_valid and any of: pending[rs1] not bypassed, pending[rs2] not bypassed, wr=1 and pending[rd] (WAW).
REQ-018 in_ready = no hazard AND (out_valid=0 OR out_ready=1); combinational, no dependence on in_valid beyond hazard terms.
REQ-019 Issue = in_valid AND in_ready; on issue, output register loads all fields next edge, out_valid=1.
REQ-020 out_valid AND out_ready with no issue -> out_valid=0 next edge; out_valid held and outputs stable while out_ready=0.
REQ-021 Latency: instruction accepted in cycle N appears on outputs in cycle N+1.
REQ-022 On issue with wr=1, pending[rd] set next edge.
REQ-023 wb_en=1 clears pending[wb_addr[3:0]] next edge.
REQ-024 Same-cycle set and clear of the same register: set wins.
REQ-025 out_imm = in_instr[15:0] sign-extended to DW.
REQ-026 Issue and drain in same cycle allowed (full throughput, one per cycle).
REQ-027 wb_en for a non-pending register: write ignored by scoreboard, no error.

Reset
REQ-028 rst=1 asynchronously forces out_valid=0, all pending bits=0, out_* data/fields=0.
REQ-029 Reset mid-operation discards held bundle and all outstanding pending bits; in-flight writebacks after reset have no scoreboard effect.
REQ-030 in_ready SHALL be 0 while rst=1.

Configuration
REQ-031 Macro OPERAND_FETCH_BYPASS_EN.
REQ-032 Defined: source rsX with wb_en=1 and wb_addr[3:0]=rsX[3:0] is "bypassed": no hazard, operand taken from wb_data instead of rf_do_X.
REQ-033 Not defined: no bypass; pending source stalls until cycle after wb_en, operand always from rf_do_X.
REQ-034 Bypass never resolves a WAW hazard in either build.

Verification
REQ-035 Reset: rst pulse mid-stream -> out_valid=0, pending=0, in_ready=1 next cycle with in_valid=1, no hazards.
REQ-036 Back-to-back: 4 independent instrs, out_ready=1 -> 4 bundles on consecutive cycles, latency 1, out_imm of 0x8000 = 0xFFFF8000.
REQ-037 RAW: issue wr to r3, then read r3; wb_en r3=0x1234 two cycles later -> with BYPASS_EN issue on wb cycle, out_a=0x1234; without, issue one cycle later, out_a=0x1234.
REQ-038 Backpressure: out_ready=0 for 3 cycles -> outputs stable, in_ready=0, no instruction lost.
REQ-039 WAW: wr r5 pending, second wr r5 stalls until wb_en r5; same-cycle clear+set of r5 leaves pending[r5]=1.
REQ-040 Address fold: rs1=5'b10010 -> rf_addr_a=5'b00010.
